// File: rtl/multi_threshold_counter.sv
// rtl/multi_threshold_counter.sv - multi-channel threshold counter with shared prescaler
module multi_threshold_counter #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int PW       = 8
) (
    input  logic                      clk,
    input  logic                      nRst,
    input  logic [PW-1:0]             presc,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       clr,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [WIDTH*CHANNELS-1:0] max,
    output logic [WIDTH*CHANNELS-1:0] cnt,
    output logic [CHANNELS-1:0]       reach_max,
    output logic [CHANNELS-1:0]       is_zero,
    output logic [CHANNELS-1:0]       tick
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;
    logic          stb;

    // >= rather than == so a presc lowered below pcnt strobes at once instead of running to wrap
    assign stb    = (pcnt_q >= presc);
    assign pcnt_d = stb ? '0 : pcnt_q + PW'(1);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] cnt_d;
        logic [WIDTH-1:0] max_w;
        logic [1:0]       mode_w;
        logic             tick_q;
        logic             tick_d;
        logic             step;
        logic             below;

        assign max_w  = max[WIDTH*i +: WIDTH];
        assign mode_w = mode[2*i +: 2];
        assign step   = en[i] & stb;
        assign below  = (cnt_q < max_w);

        always_comb begin
            cnt_d  = cnt_q;
            tick_d = 1'b0;
            if (clr[i]) begin
                cnt_d = (mode_w == 2'd3) ? max_w : '0;
            end else begin
                case (mode_w)
                    2'd0: begin
                        if (!en[i]) begin
                            cnt_d = '0;
                        end else if (step) begin
                            if (below) begin
                                cnt_d = cnt_q + ONE;
                            end else begin
                                cnt_d  = '0;
                                tick_d = 1'b1;
                            end
                        end
                    end
                    2'd1: begin
                        if (step && below) begin
                            cnt_d  = cnt_q + ONE;
                            tick_d = ((cnt_q + ONE) == max_w);
                        end
                    end
                    2'd2: begin
                        if (step) begin
                            if (below) begin
                                cnt_d = cnt_q + ONE;
                            end else begin
                                cnt_d  = '0;
                                tick_d = 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (step) begin
                            if (cnt_q != '0) begin
                                cnt_d = cnt_q - ONE;
                            end else begin
                                cnt_d  = max_w;
                                tick_d = 1'b1;
                            end
                        end
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge nRst) begin
            if (!nRst) begin
                cnt_q  <= '0;
                tick_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                tick_q <= tick_d;
            end
        end

        assign cnt[WIDTH*i +: WIDTH] = cnt_q;
        assign tick[i]               = tick_q;
        assign reach_max[i]          = ~below;
        assign is_zero[i]            = (cnt_q == '0);
    end

endmodule

// File: tb/tb_multi_threshold_counter.sv
// tb/tb_multi_threshold_counter.sv - scoreboard bench for multi_threshold_counter
module tb_multi_threshold_counter;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic [7:0]  presc = '0;
    logic [3:0]  en = '0;
    logic [3:0]  clr = '0;
    logic [7:0]  mode = '0;
    logic [63:0] mx = '0;
    logic [63:0] cnt;
    logic [3:0]  reach_max;
    logic [3:0]  is_zero;
    logic [3:0]  tick;

    int tests = 0;
    int fails = 0;

    multi_threshold_counter #(.WIDTH(16), .CHANNELS(4), .PW(8)) dut (
        .clk       (clk),
        .nRst      (nRst),
        .presc     (presc),
        .en        (en),
        .clr       (clr),
        .mode      (mode),
        .max       (mx),
        .cnt       (cnt),
        .reach_max (reach_max),
        .is_zero   (is_zero),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] cnt;
        logic [3:0]  tick;
        logic [3:0]  rm;
        logic [3:0]  iz;
        int          ec;
        int          et;
    } exp_t;

    exp_t q[$];

    int m_cnt[4];
    bit m_tick[4];
    int m_pcnt;
    int prev_ec = -1;
    int prev_et = -1;

    function automatic int chmax(input int ch);
        logic [15:0] v;
        v = mx[16*ch +: 16];
        return int'(v);
    endfunction

    task automatic model_reset();
        m_pcnt = 0;
        for (int c = 0; c < 4; c++) begin
            m_cnt[c]  = 0;
            m_tick[c] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit s;
        int mxv;
        int md;
        if (!nRst) begin
            model_reset();
            return;
        end
        s = (m_pcnt >= int'(presc));
        m_pcnt = s ? 0 : m_pcnt + 1;
        for (int c = 0; c < 4; c++) begin
            mxv = chmax(c);
            md  = int'(mode[2*c +: 2]);
            m_tick[c] = 1'b0;
            if (clr[c]) begin
                m_cnt[c] = (md == 3) ? mxv : 0;
            end else if (md == 0 && !en[c]) begin
                m_cnt[c] = 0;
            end else if (s && en[c]) begin
                if (md == 3) begin
                    if (m_cnt[c] == 0) begin m_cnt[c] = mxv; m_tick[c] = 1'b1; end
                    else m_cnt[c] = m_cnt[c] - 1;
                end else if (m_cnt[c] < mxv) begin
                    m_cnt[c] = m_cnt[c] + 1;
                    if (md == 1 && m_cnt[c] == mxv) m_tick[c] = 1'b1;
                end else if (md != 1) begin
                    m_cnt[c] = 0;
                    m_tick[c] = 1'b1;
                end
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            e.cnt[16*c +: 16] = 16'(m_cnt[c]);
            e.tick[c] = m_tick[c];
            e.rm[c]   = (m_cnt[c] >= chmax(c));
            e.iz[c]   = (m_cnt[c] == 0);
        end
        e.ec = prev_ec;
        e.et = prev_et;
        q.push_back(e);
    endtask

    // ec/et: hand-computed ch0 cnt/tick after the edge that consumes this row (-1 = unchecked)
    task automatic drive(input bit r, input logic [7:0] p, input logic [3:0] e, input logic [3:0] c,
                         input logic [7:0] m, input logic [63:0] x, input int ec, input int et);
        @(posedge clk);
        model_step();
        #1;
        nRst = r; presc = p; en = e; clr = c; mode = m; mx = x;
        if (!nRst) model_reset();
        push_exp();
        prev_ec = ec;
        prev_et = et;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                tests++;
                if (cnt !== e.cnt) begin fails++; $display("FAIL cnt act=%h exp=%h", cnt, e.cnt); end
                tests++;
                if (tick !== e.tick) begin fails++; $display("FAIL tick act=%b exp=%b", tick, e.tick); end
                tests++;
                if (reach_max !== e.rm) begin fails++; $display("FAIL reach_max act=%b exp=%b", reach_max, e.rm); end
                tests++;
                if (is_zero !== e.iz) begin fails++; $display("FAIL is_zero act=%b exp=%b", is_zero, e.iz); end
                if (e.ec >= 0) begin
                    tests++;
                    if (int'(cnt[15:0]) != e.ec) begin
                        fails++; $display("FAIL hand_cnt0 act=%0d exp=%0d", cnt[15:0], e.ec);
                    end
                    tests++;
                    if (int'(tick[0]) != e.et) begin
                        fails++; $display("FAIL hand_tick0 act=%0d exp=%0d", tick[0], e.et);
                    end
                end
            end
        end
    end

    initial begin : stim
        bit          r;
        logic [3:0]  re;
        logic [3:0]  rc;
        model_reset();
        drive(0, 0, 4'h0, 4'h0, 8'h00, 64'd0, 0, 0);
        drive(0, 0, 4'h0, 4'h0, 8'h00, 64'd0, 0, 0);
        // legacy: 0,1,2,3,0 with tick on 3->0, then en drop clears
        drive(1, 0, 4'h1, 4'h0, 8'h00, 64'd3, 1, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h00, 64'd3, 2, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h00, 64'd3, 3, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h00, 64'd3, 0, 1);
        drive(1, 0, 4'h1, 4'h0, 8'h00, 64'd3, 1, 0);
        drive(1, 0, 4'h0, 4'h0, 8'h00, 64'd3, 0, 0);
        drive(1, 0, 4'h0, 4'h0, 8'h00, 64'd3, 0, 0);
        // prescale 2, wrap max=1: tick every 6 cycles
        drive(1, 2, 4'h1, 4'h0, 8'h02, 64'd1, 0, 0);
        drive(1, 2, 4'h1, 4'h0, 8'h02, 64'd1, 0, 0);
        drive(1, 2, 4'h1, 4'h0, 8'h02, 64'd1, 1, 0);
        drive(1, 2, 4'h1, 4'h0, 8'h02, 64'd1, 1, 0);
        drive(1, 2, 4'h1, 4'h0, 8'h02, 64'd1, 1, 0);
        drive(1, 2, 4'h1, 4'h0, 8'h02, 64'd1, 0, 1);
        drive(1, 2, 4'h1, 4'h0, 8'h02, 64'd1, 0, 0);
        drive(1, 2, 4'h1, 4'h0, 8'h02, 64'd1, 0, 0);
        drive(1, 2, 4'h1, 4'h0, 8'h02, 64'd1, 1, 0);
        drive(1, 2, 4'h1, 4'h0, 8'h02, 64'd1, 1, 0);
        drive(1, 2, 4'h1, 4'h0, 8'h02, 64'd1, 1, 0);
        drive(1, 2, 4'h1, 4'h0, 8'h02, 64'd1, 0, 1);
        drive(1, 5, 4'h1, 4'h0, 8'h02, 64'd1, 0, 0);
        drive(1, 5, 4'h1, 4'h0, 8'h02, 64'd1, 0, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h02, 64'd1, 1, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h02, 64'd1, 0, 1);
        // saturate max=5: single tick, hold, clr wins over step
        drive(1, 0, 4'h1, 4'h1, 8'h01, 64'd5, 0, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h01, 64'd5, 1, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h01, 64'd5, 2, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h01, 64'd5, 3, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h01, 64'd5, 4, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h01, 64'd5, 5, 1);
        drive(1, 0, 4'h1, 4'h0, 8'h01, 64'd5, 5, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h01, 64'd5, 5, 0);
        drive(1, 0, 4'h1, 4'h1, 8'h01, 64'd5, 0, 0);
        // down/reload max=4, then max=0 ticks every step
        drive(1, 0, 4'h1, 4'h1, 8'h03, 64'd4, 4, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h03, 64'd4, 3, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h03, 64'd4, 2, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h03, 64'd4, 1, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h03, 64'd4, 0, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h03, 64'd4, 4, 1);
        drive(1, 0, 4'h1, 4'h1, 8'h03, 64'd0, 0, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h03, 64'd0, 0, 1);
        drive(1, 0, 4'h1, 4'h0, 8'h03, 64'd0, 0, 1);
        drive(1, 0, 4'h0, 4'h0, 8'h03, 64'd0, 0, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h00, 64'd0, 0, 1);
        drive(1, 0, 4'h1, 4'h0, 8'h00, 64'd0, 0, 1);
        // wrap with max lowered below cnt, then mode changes mid-run
        drive(1, 0, 4'h1, 4'h0, 8'h02, 64'd9, 1, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h02, 64'd9, 2, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h02, 64'd9, 3, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h02, 64'd1, 0, 1);
        drive(1, 0, 4'h1, 4'h0, 8'h02, 64'd1, 1, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h01, 64'd9, 2, 0);
        drive(1, 0, 4'h1, 4'h0, 8'h03, 64'd9, 1, 0);
        drive(1, 0, 4'h0, 4'h0, 8'h00, 64'd9, 0, 0);
        // four channels, modes 0..3, random en/clr, reset pulsed mid-run
        for (int k = 0; k < 300; k++) begin
            r = !(k >= 150 && k < 153);
            for (int c = 0; c < 4; c++) begin
                re[c] = ($urandom_range(0, 9) != 0);
                rc[c] = ($urandom_range(0, 24) == 0);
            end
            drive(r, 1, re, rc, 8'b11_10_01_00, {16'd4, 16'd2, 16'd5, 16'd3}, -1, -1);
        end
        for (int w = 0; w < 10 && q.size() != 0; w++) @(negedge clk);
        @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++; $display("FAIL drain act=%0d exp=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
